// File: rtl/diff_rx_pkg.sv
// diff_rx_checker shared types: lane FSM state, counter width, parameter checks.
// Optional differential pair check is enabled by DIFF_RX_PAIR_CHECK_EN.
package diff_rx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } rx_state_e;

  function automatic int cnt_w(input int lock_cycles);
    return $clog2(lock_cycles + 1);
  endfunction

  function automatic bit params_ok(
    input int ch,
    input int ss,
    input int lc,
    input int ew
  );
    return (ch >= 1) && (ch <= 32) &&
           (ss >= 2) && (ss <= 4) &&
           (lc >= 2) && (lc <= 255) &&
           (ew >= 1) && (ew <= 16);
  endfunction

endpackage

// File: rtl/diff_rx_if.sv
// diff_rx_checker bus: differential legs, clear, and per-channel link status.
// master drives the pads and clear; slave is the checker.
interface diff_rx_if #(
  parameter int CHANNELS  = 4,
  parameter int ERR_CNT_W = 8
);
  logic [CHANNELS-1:0]           diff_i_p;
  logic [CHANNELS-1:0]           diff_i_n;
  logic                          clear;
  logic [CHANNELS-1:0]           data_o;
  logic [CHANNELS-1:0]           locked_o;
  logic [CHANNELS-1:0]           err_o;
  logic [CHANNELS*ERR_CNT_W-1:0] err_cnt_o;
  logic                          all_locked_o;

  modport master (
    output diff_i_p, diff_i_n, clear,
    input  data_o, locked_o, err_o,
    input  err_cnt_o, all_locked_o
  );

  modport slave (
    input  diff_i_p, diff_i_n, clear,
    output data_o, locked_o, err_o,
    output err_cnt_o, all_locked_o
  );
endinterface

// File: rtl/diff_rx_lane.sv
// One receive lane: pad buffer, synchroniser, toggle-pattern FSM, error count.
// DIFF_RX_PAIR_CHECK_EN adds the complementary leg and flags equal-leg pairs.
module diff_rx_lane
  import diff_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CYCLES = 8,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_p,
  input  logic                 i_n,
  input  logic                 i_clear,
  output logic                 o_data,
  output logic                 o_locked,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam int CW = cnt_w(LOCK_CYCLES);
  localparam logic [CW-1:0] LC = CW'(LOCK_CYCLES);
  localparam logic [ERR_CNT_W-1:0] EMAX = '1;

  logic                   w_o;
  logic                   w_tog;
  logic                   w_bad;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  rx_state_e              r_state;
  rx_state_e              w_state;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt;
  logic                   r_err;
  logic                   w_err;
  logic                   r_locked;
  logic [ERR_CNT_W-1:0]   r_err_cnt;

  // Comparator model of the pad buffer: equal legs resolve to 0.
  assign w_o = i_p & ~i_n;

`ifdef DIFF_RX_PAIR_CHECK_EN
  logic                   w_ob;
  logic [SYNC_STAGES-1:0] r_sync_b;

  assign w_ob = i_n & ~i_p;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync_b <= '0;
    end else begin
      r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], w_ob};
    end
  end

  assign w_bad = (r_sync[SYNC_STAGES-1] == r_sync_b[SYNC_STAGES-1]);
`else
  assign w_bad = 1'b0;
`endif

  assign o_data = r_sync[SYNC_STAGES-1];
  assign w_tog  = o_data ^ r_prev;

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_err   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_tog) begin
          w_state = ACQUIRE;
          w_cnt   = CW'(1);
        end
      end
      ACQUIRE: begin
        if (w_bad) begin
          w_err = 1'b1;
          w_cnt = '0;
        end else if (r_cnt == LC) begin
          w_state = LOCKED;
        end else if (w_tog) begin
          w_cnt = r_cnt + 1'b1;
        end else begin
          w_cnt = '0;
        end
      end
      LOCKED: begin
        if (w_bad || !w_tog) begin
          w_err   = 1'b1;
          w_state = ACQUIRE;
          w_cnt   = '0;
        end
      end
      default: begin
        w_state = IDLE;
        w_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync    <= '0;
      r_prev    <= 1'b0;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_locked  <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], w_o};
      r_prev   <= o_data;
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_err    <= w_err;
      r_locked <= (w_state == LOCKED);
      // clear beats a same-cycle error; the pulse still goes out
      if (i_clear) begin
        r_err_cnt <= '0;
      end else if (w_err && (r_err_cnt != EMAX)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign o_locked  = r_locked;
  assign o_err     = r_err;
  assign o_err_cnt = r_err_cnt;

endmodule

// File: rtl/diff_rx_checker.sv
// Multi-channel differential receiver and alternating-pattern link checker.
// Define DIFF_RX_PAIR_CHECK_EN to also flag invalid (equal-leg) pairs.
module diff_rx_checker
  import diff_rx_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CYCLES = 8,
  parameter int ERR_CNT_W   = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  diff_rx_if.slave  bus
);

  logic [1:0]                    r_rst_sync;
  logic                          w_rst_n;
  logic [CHANNELS-1:0]           w_data;
  logic [CHANNELS-1:0]           w_locked;
  logic [CHANNELS-1:0]           w_err;
  logic [CHANNELS*ERR_CNT_W-1:0] w_err_cnt;
  logic                          r_all_locked;

  if (!params_ok(CHANNELS, SYNC_STAGES, LOCK_CYCLES, ERR_CNT_W)) begin : g_bad_params
    $error("diff_rx_checker: parameter out of range");
  end

  // Assert immediately, release two edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    diff_rx_lane #(
      .SYNC_STAGES (SYNC_STAGES),
      .LOCK_CYCLES (LOCK_CYCLES),
      .ERR_CNT_W   (ERR_CNT_W)
    ) u_lane (
      .i_clk     (clk),
      .i_rst_n   (w_rst_n),
      .i_p       (bus.diff_i_p[g]),
      .i_n       (bus.diff_i_n[g]),
      .i_clear   (bus.clear),
      .o_data    (w_data[g]),
      .o_locked  (w_locked[g]),
      .o_err     (w_err[g]),
      .o_err_cnt (w_err_cnt[g*ERR_CNT_W +: ERR_CNT_W])
    );
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_all_locked <= 1'b0;
    end else begin
      r_all_locked <= &w_locked;
    end
  end

  assign bus.data_o       = w_data;
  assign bus.locked_o     = w_locked;
  assign bus.err_o        = w_err;
  assign bus.err_cnt_o    = w_err_cnt;
  assign bus.all_locked_o = r_all_locked;

endmodule

// File: doc/diff_rx_checker.md
# diff_rx_checker

Multi-channel differential input receiver and link checker for the diff_io feature tests. It terminates CHANNELS differential pairs through per-channel IBUFDS primitives and synchronises each received bit into `clk`. It then checks that every channel carries the alternating 0/1 test pattern produced by the feature benches. Per-channel lock, error pulses and saturating error counters go to the top-level LEDs and to bench assertions.

## Interface
Parameters:
- CHANNELS, 4, number of differential pairs (1..32)
- SYNC_STAGES, 2, synchroniser flops per channel (2..4)
- LOCK_CYCLES, 8, consecutive correct toggles required to declare lock (2..255)
- ERR_CNT_W, 8, width of each per-channel error counter (1..16)

Ports:
- clk  in  1  single system clock; all state on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- diff_i_p  in  CHANNELS  positive leg of each pair
- diff_i_n  in  CHANNELS  negative leg of each pair
- clear  in  1  synchronous one-cycle pulse: zero all error counters
- data_o  out  CHANNELS  synchronised received bit per channel
- locked_o  out  CHANNELS  channel is in LOCKED
- err_o  out  CHANNELS  one-cycle error pulse per channel
- err_cnt_o  out  CHANNELS*ERR_CNT_W  packed saturating counters, channel 0 in LSBs
- all_locked_o  out  1  AND of locked_o

## Operation
- Per channel: IBUFDS output passes through a SYNC_STAGES flop chain. The last stage is data_o. A further register, prev, holds the previous data_o.
- toggle = data_o != prev; miss = data_o == prev.
- Per-channel FSM, 2-bit state:
  - IDLE (reset state): no checking. On the first toggle, go to ACQUIRE with cnt=1.
  - ACQUIRE: on toggle, cnt++. When cnt reaches LOCK_CYCLES, go to LOCKED. On miss, cnt=0 and stay in ACQUIRE with no error.
  - LOCKED: on toggle, stay. On miss, raise err_o for one cycle, increment err_cnt, go to ACQUIRE with cnt=0.
- cnt is $clog2(LOCK_CYCLES+1) bits wide. It is held in LOCKED.
- err_cnt saturates at 2^ERR_CNT_W-1 and never wraps.
- clear zeroes every err_cnt. If clear and an error occur in the same cycle, clear wins: the count becomes 0, but err_o still pulses.
- Channels are fully independent. Only all_locked_o combines them.

## Timing
- Reset values: data_o=0, prev=0, locked_o=0, err_o=0, err_cnt_o=0, all_locked_o=0, all FSMs in IDLE with cnt=0.
- Asserting rst_n mid-operation clears everything immediately, asynchronously. Deassertion is synchronised internally by a 2-flop reset synchroniser, so the release takes effect on the second clk edge.
- Input to data_o latency: SYNC_STAGES cycles.
- err_o and locked_o are registered. They update in the cycle after the offending or qualifying data_o sample.
- Worst-case lock, from the first data_o change: LOCK_CYCLES cycles, then locked_o rises on the next edge.
- all_locked_o is registered, one cycle after locked_o.

## Configuration
- Macro: DIFF_RX_PAIR_CHECK_EN.
- Defined:
  - Each channel uses IBUFDS_DIFF_OUT instead of IBUFDS.
  - O and OB are each synchronised.
  - O == OB, i.e. an invalid/common-mode pair, is an error in ACQUIRE and LOCKED. It pulses err_o, increments err_cnt and forces ACQUIRE with cnt=0.
  - In IDLE, an invalid pair is ignored.
  - A pattern miss and an invalid pair in the same cycle count as one error.
- Undefined: plain IBUFDS, no pair check, OB logic absent.

## Structure
- Package diff_rx_pkg holds:
  - state typedef: IDLE=2'd0, ACQUIRE=2'd1, LOCKED=2'd2.
  - width helper for cnt.
  - parameter range checks.
- Sub-module diff_rx_lane holds the primitive, synchroniser, prev register, FSM and err_cnt for one channel.
- diff_rx_checker contains:
  - the reset synchroniser.
  - a generate loop of CHANNELS × diff_rx_lane.
  - the all_locked_o register.

## Test plan
All scenarios use CHANNELS=4, SYNC_STAGES=2, LOCK_CYCLES=8 unless stated.

- Lock from reset: drive p=sig, n=!sig, with sig toggling every cycle after rst_n goes high. Expect locked_o=4'hF exactly 9 cycles after the first data_o change, all_locked_o one cycle later, and err_cnt_o=0.
- Single miss: hold channel 1 sig for one extra cycle while LOCKED. Expect err_o[1] for one cycle, err_cnt[1]=1, locked_o[1]=0, relock after 8 toggles. Other channels stay locked.
- Saturation: ERR_CNT_W=2, inject 5 misses on channel 0, each after relock. Expect err_cnt[0]=3 and 5 err_o pulses.
- Clear collision: assert clear in the same cycle as a channel 2 miss with err_cnt[2]=4. Expect err_o[2] to pulse and err_cnt[2]=0 afterwards.
- Pair check (macro defined): while locked, force channel 3 p=n=1 for one cycle. Expect err_o[3]=1, err_cnt[3]=1, locked_o[3]=0. With the macro undefined, expect no error from the same stimulus.
- Reset mid-lock: pull rst_n low while all channels are locked. Expect all outputs 0 immediately, and IDLE until a toggle is seen after release.
